// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bundle for the bit-serial subtractor.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one full-subtractor cell and
// a registered borrow; one bit per clock with a start/done handshake.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave sub_io
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  // Holds the low WIDTH-1 result bits; the final bit joins them on the edge into DONE.
  logic [WIDTH-2:0] res_q, res_d;
  logic             borrow_q, borrow_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;

  logic             x, y, w, d, nb;
  logic [WIDTH-1:0] shift_in;

  assign x        = a_sh_q[0];
  assign y        = b_sh_q[0];
  assign w        = borrow_q;
  assign d        = x ^ y ^ w;
  assign nb       = (~x & y) | (~(x ^ y) & w);
  assign shift_in = {d, res_q};

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (sub_io.start) begin
          state_d  = StRun;
          a_sh_d   = sub_io.a;
          b_sh_d   = sub_io.b;
          borrow_d = sub_io.bin;
          cnt_d    = '0;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
        res_d    = shift_in[WIDTH-1:1];
        borrow_d = nb;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StDone;
          diff_d  = shift_in;
          bout_d  = nb;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
    end
  end

  assign sub_io.busy = (state_q == StRun);
  assign sub_io.done = (state_q == StDone);
  assign sub_io.diff = diff_q;
  assign sub_io.bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized scoreboard bench for serial_subtractor: the driver queues the arithmetic
// result and expected done cycle; a negedge monitor checks every done pulse and held outputs.
module tb_serial_subtractor;
  localparam int unsigned W = 8;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb_q[$];
  exp_t held;
  int   run_len = 0;

  serial_subtractor_if #(.WIDTH(W)) sub ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .sub_io (sub.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: plain unsigned arithmetic on WIDTH+1 bits; the top bit is the borrow.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic bi, input int done_cyc);
    exp_t e;
    logic [W:0] r;
    r      = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
    e.diff = r[W-1:0];
    e.bout = r[W];
    e.cyc  = done_cyc;
    return e;
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (rst) begin
      held.diff = '0;
      held.bout = 1'b0;
      run_len   = 0;
    end else begin
      if (sub.done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 64'(sub.done), 64'(0));
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("diff", 64'(sub.diff), 64'(e.diff));
          chk("bout", 64'(sub.bout), 64'(e.bout));
          chk("done_cycle", 64'(cyc), 64'(e.cyc));
          chk("busy_in_done", 64'(sub.busy), 64'(0));
          held = e;
        end
      end else begin
        chk("hold_diff", 64'(sub.diff), 64'(held.diff));
        chk("hold_bout", 64'(sub.bout), 64'(held.bout));
      end
      if (sub.busy) begin
        run_len++;
      end else if (run_len != 0) begin
        chk("busy_len", 64'(run_len), 64'(W));
        run_len = 0;
      end
    end
  end

  // Call at #1 after an edge where the DUT is idle or in its done cycle.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    sub.start = 1'b1;
    sub.a     = a;
    sub.b     = b;
    sub.bin   = bi;
    sb_q.push_back(model(a, b, bi, cyc + 1 + W));
    @(posedge clk);
    #1;
    sub.start = 1'b0;
  endtask

  // Runs the W RUN edges after launch; a start at step ign is issued and must be ignored.
  task automatic run_phase(input int ign, input logic [W-1:0] ga, input logic [W-1:0] gb);
    for (int k = 0; k < int'(W); k++) begin
      sub.start = (k == ign);
      sub.a     = (k == ign) ? ga : W'($urandom);
      sub.b     = (k == ign) ? gb : W'($urandom);
      sub.bin   = 1'($urandom);
      @(posedge clk);
      #1;
    end
    sub.start = 1'b0;
  endtask

  task automatic idle(input int n);
    sub.start = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    sub.start = 1'b0;
    sub.a     = '0;
    sub.b     = '0;
    sub.bin   = 1'b0;
    #2;
    chk("rst_busy", 64'(sub.busy), 64'(0));
    chk("rst_done", 64'(sub.done), 64'(0));
    chk("rst_diff", 64'(sub.diff), 64'(0));
    chk("rst_bout", 64'(sub.bout), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // 0x5A-0x3C then back-to-back 0x03-0x05 launched in the done cycle
    launch(8'h5A, 8'h3C, 1'b0);
    run_phase(-1, '0, '0);
    launch(8'h03, 8'h05, 1'b0);
    run_phase(-1, '0, '0);
    idle(2);
    launch(8'h00, 8'h01, 1'b0);
    run_phase(-1, '0, '0);
    idle(1);
    launch(8'h10, 8'h10, 1'b1);
    run_phase(-1, '0, '0);
    idle(1);
    launch(8'hFF, 8'h00, 1'b1);
    run_phase(-1, '0, '0);
    idle(1);
    launch(8'h80, 8'h01, 1'b0);
    run_phase(3, 8'h00, 8'hFF);
    idle(2);

    // Abort mid-run at count=4; outputs must clear without a clock edge
    launch(8'hC3, 8'h21, 1'b1);
    idle(4);
    rst = 1'b1;
    #1;
    chk("abort_busy", 64'(sub.busy), 64'(0));
    chk("abort_done", 64'(sub.done), 64'(0));
    chk("abort_diff", 64'(sub.diff), 64'(0));
    chk("abort_bout", 64'(sub.bout), 64'(0));
    sb_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(W + 3);
    launch(8'h42, 8'h17, 1'b0);
    run_phase(-1, '0, '0);
    idle(1);

    for (int i = 0; i < 60; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 10 == 0) ra = '0;
      if (i % 10 == 1) rb = '1;
      launch(ra, rb, 1'($urandom));
      run_phase(($urandom_range(0, 2) == 0) ? int'($urandom_range(0, W - 1)) : -1,
                W'($urandom), W'($urandom));
      if ($urandom_range(0, 2) != 0) idle(int'($urandom_range(1, 3)));
    end

    // Drain with a bounded wait
    for (int k = 0; k < 3 * int'(W) && sb_q.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    idle(2);
    chk("queue_empty", 64'(sb_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
